// File: rtl/log_ram_capture.sv
// ============================================================================
//  Module      : log_ram_capture
//  Description : Capture-RAM datapath beneath the RAM-logging FSM. Writes
//                qualified samples into an internal RAM at a wrapping write
//                address that is returned to the FSM for full detection, and
//                offers a registered, read-first port for draining the log.
//  Options     : LOG_DECIMATION_EN - adds i_decim and keeps only one qualified
//                sample out of every (i_decim+1).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module log_ram_capture #(
  parameter int NB_COUNTER = 3,
  parameter int NB_DATA    = 16,
  parameter int NB_DECIM   = 4
) (
  input  logic                  clock,
  input  logic                  i_reset,
  input  logic                  i_fsm_rst,
  input  logic                  i_fsm_enb,
  input  logic [NB_DATA-1:0]    i_data,
  input  logic                  i_data_valid,
`ifdef LOG_DECIMATION_EN
  input  logic [NB_DECIM-1:0]   i_decim,
`endif
  input  logic                  i_rd_enb,
  input  logic [NB_COUNTER-1:0] i_rd_addr,
  output logic [NB_COUNTER-1:0] o_counter_addr,
  output logic                  o_wr_done,
  output logic [NB_DATA-1:0]    o_rd_data,
  output logic                  o_rd_valid
);

  localparam int DEPTH = 2 ** NB_COUNTER;

  logic [NB_DATA-1:0] mem [DEPTH];

  // A sample is a candidate for logging only while the FSM enables capture
  // and is not clearing it; a clear always wins over a concurrent sample.
  logic qualified;
  logic decim_hit;
  logic write_event;
  logic last_addr;

  assign qualified   = i_fsm_enb & i_data_valid & ~i_fsm_rst;
  assign write_event = qualified & decim_hit & i_reset;
  assign last_addr   = (o_counter_addr == {NB_COUNTER{1'b1}});

`ifdef LOG_DECIMATION_EN
  logic [NB_DECIM-1:0] decim_count;

  // Compare against the live i_decim so a change applies at the next sample.
  assign decim_hit = (decim_count == i_decim);

  // Count qualified samples, restarting after each one that is kept.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      decim_count <= '0;
    end else if (i_fsm_rst) begin
      decim_count <= '0;
    end else if (qualified) begin
      decim_count <= decim_hit ? '0 : decim_count + NB_DECIM'(1);
    end
  end
`else
  assign decim_hit = 1'b1;
`endif

  // Write address and sticky full flag; the address wraps naturally at DEPTH.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      o_counter_addr <= '0;
      o_wr_done      <= 1'b0;
    end else if (i_fsm_rst) begin
      o_counter_addr <= '0;
      o_wr_done      <= 1'b0;
    end else if (write_event) begin
      o_counter_addr <= o_counter_addr + NB_COUNTER'(1);
      if (last_addr) begin
        o_wr_done <= 1'b1;
      end
    end
  end

  // Capture RAM storage; contents survive both resets by design.
  always_ff @(posedge clock) begin
    if (write_event) begin
      mem[o_counter_addr] <= i_data;
    end
  end

  // Registered read port; sampling mem before the write lands gives read-first.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= i_rd_enb;
      if (i_rd_enb) begin
        o_rd_data <= mem[i_rd_addr];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_log_ram_capture.sv
// ============================================================================
//  Module      : tb_log_ram_capture
//  Description : Directed self-checking bench for log_ram_capture. The
//                decimation scenario is built only with LOG_DECIMATION_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_log_ram_capture;

  localparam int NB_COUNTER = 3;
  localparam int NB_DATA    = 16;
  localparam int NB_DECIM   = 4;

  logic                  clock = 1'b0;
  logic                  i_reset;
  logic                  i_fsm_rst;
  logic                  i_fsm_enb;
  logic [NB_DATA-1:0]    i_data;
  logic                  i_data_valid;
`ifdef LOG_DECIMATION_EN
  logic [NB_DECIM-1:0]   i_decim;
`endif
  logic                  i_rd_enb;
  logic [NB_COUNTER-1:0] i_rd_addr;
  logic [NB_COUNTER-1:0] o_counter_addr;
  logic                  o_wr_done;
  logic [NB_DATA-1:0]    o_rd_data;
  logic                  o_rd_valid;

  int vectors     = 0;
  int miscompares = 0;

  log_ram_capture #(
    .NB_COUNTER (NB_COUNTER),
    .NB_DATA    (NB_DATA),
    .NB_DECIM   (NB_DECIM)
  ) dut (
    .clock          (clock),
    .i_reset        (i_reset),
    .i_fsm_rst      (i_fsm_rst),
    .i_fsm_enb      (i_fsm_enb),
    .i_data         (i_data),
    .i_data_valid   (i_data_valid),
`ifdef LOG_DECIMATION_EN
    .i_decim        (i_decim),
`endif
    .i_rd_enb       (i_rd_enb),
    .i_rd_addr      (i_rd_addr),
    .o_counter_addr (o_counter_addr),
    .o_wr_done      (o_wr_done),
    .o_rd_data      (o_rd_data),
    .o_rd_valid     (o_rd_valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fsm_clear();
    i_fsm_rst = 1'b1;
    tick();
    i_fsm_rst = 1'b0;
  endtask

  task automatic write(input logic [NB_DATA-1:0] d);
    i_fsm_enb    = 1'b1;
    i_data_valid = 1'b1;
    i_data       = d;
    tick();
    i_data_valid = 1'b0;
  endtask

  task automatic read_check(input logic [NB_COUNTER-1:0] a, input logic [NB_DATA-1:0] exp, input string tag);
    i_rd_enb  = 1'b1;
    i_rd_addr = a;
    tick();
    i_rd_enb  = 1'b0;
    check({tag, "_data"}, 32'(o_rd_data), 32'(exp));
    check({tag, "_valid"}, 32'(o_rd_valid), 32'd1);
  endtask

  initial begin
    i_reset      = 1'b0;
    i_fsm_rst    = 1'b0;
    i_fsm_enb    = 1'b0;
    i_data       = '0;
    i_data_valid = 1'b0;
    i_rd_enb     = 1'b0;
    i_rd_addr    = '0;
`ifdef LOG_DECIMATION_EN
    i_decim      = '0;
`endif
    #12;
    check("rst_addr",   32'(o_counter_addr), 32'd0);
    check("rst_done",   32'(o_wr_done),      32'd0);
    check("rst_rdata",  32'(o_rd_data),      32'd0);
    check("rst_rvalid", 32'(o_rd_valid),     32'd0);
    i_reset = 1'b1;
    tick();

    // Fill all eight locations, address wraps to 0 and full flag sets.
    fsm_clear();
    for (int k = 1; k <= 8; k++) begin
      write(NB_DATA'(k * 16'h0101));
      check($sformatf("fill_addr%0d", k), 32'(o_counter_addr), 32'(k % 8));
      check($sformatf("fill_done%0d", k), 32'(o_wr_done), (k == 8) ? 32'd1 : 32'd0);
    end
    i_fsm_enb = 1'b0;
    for (int a = 0; a < 8; a++) begin
      read_check(NB_COUNTER'(a), NB_DATA'((a + 1) * 16'h0101), $sformatf("drain%0d", a));
    end
    tick();
    check("rd_idle_valid", 32'(o_rd_valid), 32'd0);
    check("rd_idle_hold",  32'(o_rd_data),  32'h0808);
    check("done_hold",     32'(o_wr_done),  32'd1);
    check("addr_hold",     32'(o_counter_addr), 32'd0);

    // Late FSM: write past the wrap overwrites address 0, flag stays set.
    write(16'h0909);
    check("wrap_addr", 32'(o_counter_addr), 32'd1);
    check("wrap_done", 32'(o_wr_done),      32'd1);
    i_fsm_enb = 1'b0;
    read_check(3'd0, 16'h0909, "wrap_rd0");

    // Valid gaps do not advance the address.
    fsm_clear();
    check("clr_addr", 32'(o_counter_addr), 32'd0);
    check("clr_done", 32'(o_wr_done),      32'd0);
    i_fsm_enb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_data_valid = (k % 2 == 0);
      i_data       = NB_DATA'(16'h7000 + k);
      tick();
      check($sformatf("gap_addr%0d", k), 32'(o_counter_addr), 32'((k / 2) + 1));
    end
    i_data_valid = 1'b0;

    // Clear colliding with a write at address 5 drops the sample.
    write(16'h3333);
    write(16'h4444);
    write(16'h5555);
    check("pre5_addr", 32'(o_counter_addr), 32'd5);
    i_fsm_rst    = 1'b1;
    i_data_valid = 1'b1;
    i_data       = 16'hDEAD;
    tick();
    i_fsm_rst    = 1'b0;
    i_data_valid = 1'b0;
    i_fsm_enb    = 1'b0;
    check("col_addr", 32'(o_counter_addr), 32'd0);
    check("col_done", 32'(o_wr_done),      32'd0);
    read_check(3'd5, 16'h0606, "col_mem5");
    read_check(3'd2, 16'h3333, "col_mem2");

    // Same-cycle read and write at address 2 returns the old word.
    write(16'h1111);
    write(16'h2222);
    write(16'hAAAA);
    fsm_clear();
    write(16'h0001);
    write(16'h0002);
    i_data_valid = 1'b1;
    i_data       = 16'h5555;
    i_rd_enb     = 1'b1;
    i_rd_addr    = 3'd2;
    tick();
    i_data_valid = 1'b0;
    i_rd_enb     = 1'b0;
    i_fsm_enb    = 1'b0;
    check("rfirst_data", 32'(o_rd_data),      32'hAAAA);
    check("rfirst_addr", 32'(o_counter_addr), 32'd3);
    read_check(3'd2, 16'h5555, "reread2");

    // Asynchronous reset mid-capture clears outputs without a clock edge.
    i_fsm_enb    = 1'b1;
    i_data_valid = 1'b1;
    i_data       = 16'hBEEF;
    i_rd_enb     = 1'b1;
    i_rd_addr    = 3'd1;
    tick();
    check("pre_arst_valid", 32'(o_rd_valid), 32'd1);
    #2;
    i_reset = 1'b0;
    #1;
    check("arst_addr",   32'(o_counter_addr), 32'd0);
    check("arst_done",   32'(o_wr_done),      32'd0);
    check("arst_rdata",  32'(o_rd_data),      32'd0);
    check("arst_rvalid", 32'(o_rd_valid),     32'd0);
    i_fsm_enb    = 1'b0;
    i_data_valid = 1'b0;
    i_rd_enb     = 1'b0;
    #4;
    i_reset = 1'b1;
    tick();

`ifdef LOG_DECIMATION_EN
    // Keep every third sample: 3, 6, 9 land at addresses 0..2.
    i_decim = 4'd2;
    fsm_clear();
    for (int k = 1; k <= 9; k++) begin
      write(NB_DATA'(k));
    end
    i_fsm_enb = 1'b0;
    check("dec_addr", 32'(o_counter_addr), 32'd3);
    read_check(3'd0, 16'd3, "dec_mem0");
    read_check(3'd1, 16'd6, "dec_mem1");
    read_check(3'd2, 16'd9, "dec_mem2");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
